// File: rtl/piso_tx_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | piso_ctrl_pkg : shared state encoding and register control codes           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package piso_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } piso_state_t;

  localparam logic LS_LOAD  = 1'b0;
  localparam logic LS_SHIFT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/piso_tx_ctrl_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | piso_reg : parallel-load, MSB-first shift register with enable             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module piso_reg
  import piso_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ls,
  input  logic             d,
  input  logic [WIDTH-1:0] dp,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      if (ls == LS_LOAD) begin
        q <= dp;
      end else begin
        q <= {q[WIDTH-2:0], d};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/piso_tx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | piso_tx_ctrl : valid/ready word intake, MSB-first serial stream, done pulse|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module piso_tx_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  piso_state_t      r_state, w_state_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_q;
  logic             w_en, w_ls, w_capture;
  logic             w_unused_q;

  assign w_capture = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_capture) begin
        r_word <= in_data;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_en        = 1'b0;
    w_ls        = LS_SHIFT;
    in_ready    = 1'b0;
    ser_valid   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_en        = 1'b1;
        w_ls        = LS_LOAD;
        w_count_nxt = '0;
        busy        = 1'b1;
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        // The counter parks at the last index rather than wrapping.
        if (ser_ready) begin
          w_en = 1'b1;
          w_ls = LS_SHIFT;
          if (r_count == c_last) w_state_nxt = DONE;
          else                   w_count_nxt = r_count + CW'(1);
        end
      end
      DONE: begin
        done        = 1'b1;
        in_ready    = 1'b1;
        w_state_nxt = in_valid ? LOAD : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  piso_reg #(.WIDTH(WIDTH)) u_reg (
    .clk (clk),
    .rst (rst),
    .en  (w_en),
    .ls  (w_ls),
    .d   (1'b0),
    .dp  (r_word),
    .q   (w_q)
  );

  assign ser_out    = ser_valid & w_q[WIDTH-1];
  assign w_unused_q = ^w_q[WIDTH-2:0];

endmodule
`default_nettype wire

// File: tb/tb_piso_tx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_piso_tx_ctrl : random + directed bench against a bit-queue model        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_piso_tx_ctrl;

  typedef bit bq_t[$];

  logic       clk, rst, in_valid, ser_ready;
  logic [7:0] data;
  logic       rdy4, so4, sv4, busy4, done4;
  logic       rdy8, so8, sv8, busy8, done8;

  int n_chk = 0;
  int n_pass = 0;
  int ncyc = 0;

  // Model: each accepted word becomes a queue of bits, hidden for one load cycle.
  bq_t mq4, mq8;
  bit  ml4, ml8, md4, md8;

  bq_t obs4, obs8;
  int  dcnt4, dcnt8;
  int  dstep4[$];

  piso_tx_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(data[3:0]), .in_ready(rdy4),
    .ser_out(so4), .ser_valid(sv4), .ser_ready(ser_ready), .busy(busy4), .done(done4)
  );

  piso_tx_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(data), .in_ready(rdy8),
    .ser_out(so8), .ser_valid(sv8), .ser_ready(ser_ready), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ncyc);
  endtask

  task automatic model_one(input int w, input bit v, input logic [7:0] d, input bit sr,
                           inout bq_t q, inout bit ld, inout bit dn);
    bit rdy, sv, b;
    rdy = !ld && q.size() == 0;
    sv  = !ld && q.size() != 0;
    dn  = 1'b0;
    if (ld) begin
      ld = 1'b0;
    end else if (sv && sr) begin
      b = q.pop_front();
      if (q.size() == 0) dn = 1'b1;
    end
    if (rdy && v) begin
      for (int i = w - 1; i >= 0; i--) q.push_back(d[i]);
      ld = 1'b1;
    end
  endtask

  task automatic check_one(input string p, input bq_t q, input bit ld, input bit dn,
                           input logic rdy, input logic sv, input logic so,
                           input logic bsy, input logic dne);
    bit e_sv;
    e_sv = !ld && q.size() != 0;
    chk({p, ".in_ready"}, rdy, !ld && q.size() == 0);
    chk({p, ".ser_valid"}, sv, e_sv);
    chk({p, ".ser_out"}, so, e_sv ? q[0] : 1'b0);
    chk({p, ".busy"}, bsy, ld || q.size() != 0);
    chk({p, ".done"}, dne, dn);
  endtask

  task automatic check_all();
    check_one("w4", mq4, ml4, md4, rdy4, sv4, so4, busy4, done4);
    check_one("w8", mq8, ml8, md8, rdy8, sv8, so8, busy8, done8);
  endtask

  function automatic int q2i(input bq_t q);
    int v = 0;
    foreach (q[i]) v = (v << 1) | int'(q[i]);
    return v;
  endfunction

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic step(input bit v, input logic [7:0] d, input bit sr);
    in_valid  = v;
    data      = d;
    ser_ready = sr;
    if (sv4 && sr) obs4.push_back(so4);
    if (sv8 && sr) obs8.push_back(so8);
    @(posedge clk);
    model_one(4, v, d, sr, mq4, ml4, md4);
    model_one(8, v, d, sr, mq8, ml8, md8);
    @(negedge clk);
    ncyc++;
    check_all();
    if (done4) begin dcnt4++; dstep4.push_back(ncyc); end
    if (done8) dcnt8++;
  endtask

  task automatic clear_obs();
    obs4 = {}; obs8 = {}; dcnt4 = 0; dcnt8 = 0; dstep4 = {};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    mq4 = {}; mq8 = {}; ml4 = 0; ml8 = 0; md4 = 0; md8 = 0;
    check_all();
    clear_obs();
    #1 rst = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; data = 8'h00; ser_ready = 1'b0;
    mq4 = {}; mq8 = {}; ml4 = 0; ml8 = 0; md4 = 0; md8 = 0;
    clear_obs();
    #1 check_all();
    #10 rst = 1'b0;
    @(negedge clk);
    check_all();

    // Single word, no stalls.
    clear_obs();
    step(1'b1, 8'h0B, 1'b1);
    drain(12);
    chk("t2.bits4", q2i(obs4), 32'hB);
    chk("t2.nbits4", obs4.size(), 4);
    chk("t2.done4", dcnt4, 1);

    // Stall for three cycles on the first bit.
    clear_obs();
    step(1'b1, 8'h08, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    drain(12);
    chk("t3.bits4", q2i(obs4), 32'h8);
    chk("t3.nbits4", obs4.size(), 4);
    chk("t3.done4", dcnt4, 1);

    // Back-to-back words with in_valid held.
    clear_obs();
    step(1'b1, 8'h05, 1'b1);
    repeat (6) step(1'b1, 8'h0B, 1'b1);
    drain(14);
    chk("t4.bits4", q2i(obs4), 32'h5B);
    chk("t4.nbits4", obs4.size(), 8);
    chk("t4.done4", dcnt4, 2);
    if (dstep4.size() == 2) chk("t4.spacing", dstep4[1] - dstep4[0], 6);
    else chk("t4.ndone", dstep4.size(), 2);

    // Busy word ignored, reset mid-word, then a fresh word.
    clear_obs();
    step(1'b1, 8'h0C, 1'b1);
    repeat (3) step(1'b1, 8'h0F, 1'b1);
    chk("t5.busy_rdy", rdy4, 1'b0);
    do_reset();
    step(1'b0, 8'h00, 1'b1);
    chk("t5.no_done", dcnt4, 0);
    step(1'b1, 8'h03, 1'b1);
    drain(12);
    chk("t5.bits4", q2i(obs4), 32'h3);
    chk("t5.done4", dcnt4, 1);

    // Eight-bit word on the wide instance.
    clear_obs();
    step(1'b1, 8'hA5, 1'b1);
    drain(12);
    chk("t6.bits8", q2i(obs8), 32'hA5);
    chk("t6.nbits8", obs8.size(), 8);
    chk("t6.done8", dcnt8, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      else step(1'($urandom_range(1)), 8'($urandom), $urandom_range(9) < 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
